burst_decoder: RTL
==================

BURST_DECODER -- requirements
Module: burst_decoder

Interface
REQ-001 SHALL have parameter IN_W, default 2, meaning code width.
REQ-002 SHALL have parameter NUM_OUT, default 4, meaning one-hot output width; legal range 2..2**IN_W.
REQ-003 SHALL have parameter LEN_W, default 4, meaning burst-length field width.
REQ-004 SHALL have port clk  input  1  meaning sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  meaning asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  meaning request present.
REQ-007 SHALL have port in_ready  output  1  meaning request accepted this cycle if in_valid.
REQ-008 SHALL have port in_code  input  IN_W  meaning start code.
REQ-009 SHALL have port in_len  input  LEN_W  meaning beats minus one.
REQ-010 SHALL have port in_en  input  1  meaning decode enable.
REQ-011 SHALL have port out_valid  output  1  meaning output beat present.
REQ-012 SHALL have port out_ready  input  1  meaning consumer takes beat.
REQ-013 SHALL have port out_onehot  output  NUM_OUT  meaning decoded strobe, registered.

Function
REQ-014 SHALL use states IDLE and RUN; IDLE->RUN on accept; RUN->IDLE on last-beat handshake with no new accept.
REQ-015 SHALL drive in_ready = (state==IDLE) | (last beat & out_valid & out_ready), allowing back-to-back bursts without bubble.
REQ-016 SHALL present first beat registered one cycle after the accept cycle (latency 1).
REQ-017 SHALL, for in_en=1 and in_code<NUM_OUT, emit in_len+1 beats; beat k carries bit ((in_code+k) mod NUM_OUT) set, others zero.
REQ-018 SHALL wrap code from NUM_OUT-1 to 0 within a burst, never visiting codes >= NUM_OUT.
REQ-019 SHALL, for in_en=0, emit exactly one beat of all zeros, ignoring in_len.
REQ-020 SHALL, for in_en=1 and in_code>=NUM_OUT, emit exactly one all-zero beat, ignoring in_len.
REQ-021 SHALL hold out_onehot and out_valid stable while out_valid & !out_ready.
REQ-022 SHALL advance code and remaining count only on out_valid & out_ready.
REQ-023 SHALL never produce X on any output; no default/unknown assignments.
REQ-024 SHALL treat in_len of all ones as 2**LEN_W beats with no overflow of the remaining counter.

Reset
REQ-025 SHALL, on rst_n low, asynchronously force state=IDLE, out_valid=0, out_onehot=0, internal code and count=0; in_ready=1 while in reset-released IDLE.
REQ-026 SHALL abandon any in-flight burst when reset asserts mid-burst; no beats resume after release.

Configuration
REQ-027 SHALL recognise macro BURST_DECODER_RANGE_CHK_EN.
REQ-028 SHALL, with macro defined, add port out_err  output  1, asserted with the all-zero beat of REQ-020 and held under stall, 0 otherwise, 0 at reset.
REQ-029 SHALL, without macro, omit out_err; REQ-020 behaviour unchanged.

Structure
REQ-030 SHALL place the state enum typedef and the beat-count width helper constant in package burst_decoder_pkg.
REQ-031 SHALL instantiate one combinational sub-module onehot_dec (IN_W code, enable, NUM_OUT one-hot, zero when disabled or out of range).
REQ-032 SHALL keep all sequential logic in burst_decoder; onehot_dec has no clock.

Verification
REQ-033 SHALL cover: defaults, code=2, len=3, en=1, out_ready=1 -> beats 0100,1000,0001,0010 on four consecutive cycles, then IDLE.
REQ-034 SHALL cover: en=0, code=1, len=5 -> single beat 0000, in_ready high next cycle.
REQ-035 SHALL cover: code=1, len=1, out_ready low 3 cycles on first beat -> 0010 held 4 cycles, then 0100, no drop or repeat.
REQ-036 SHALL cover: two requests back-to-back (code=0 len=0, code=3 len=0) -> 0001 then 1000 on consecutive cycles, no bubble.
REQ-037 SHALL cover: NUM_OUT=3, IN_W=2, code=3, macro on -> single beat 000 with out_err=1; code=2 len=1 -> 100,001.
REQ-038 SHALL cover: rst_n low during beat 2 of 4-beat burst -> out_valid=0 immediately, remains 0 after release until new accept.

Source files
------------

// File: rtl/burst_decoder_pkg.sv
// Shared types and sizing helpers for burst_decoder.
package burst_decoder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // The remaining-beat counter holds the number of beats still owed after
   // the one on the output. A burst of 2**len_w beats therefore needs only
   // len_w bits.
   function automatic int unsigned beat_cnt_w(input int unsigned len_w);
      return len_w;
   endfunction

endpackage

// File: rtl/burst_decoder_onehot_dec.sv
// Combinational code-to-one-hot decoder. The output is zero when disabled or when the code is out of range.
module onehot_dec #(
   parameter int unsigned IN_W    = 2,
   parameter int unsigned NUM_OUT = 4
) (
   input  logic [IN_W-1:0]    code_i,
   input  logic               en_i,
   output logic [NUM_OUT-1:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
         onehot_o[i] = en_i && (32'(code_i) == i);
      end
   end

endmodule

// File: rtl/burst_decoder.sv
// Burst decoder: turns a (code, length) request into a stream of rotating one-hot beats.
// Optional macro BURST_DECODER_RANGE_CHK_EN adds out_err for out-of-range codes.
module burst_decoder #(
   parameter int unsigned IN_W    = 2,
   parameter int unsigned NUM_OUT = 4,
   parameter int unsigned LEN_W   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [IN_W-1:0]    in_code,
   input  logic [LEN_W-1:0]   in_len,
   input  logic               in_en,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NUM_OUT-1:0] out_onehot
`ifdef BURST_DECODER_RANGE_CHK_EN
   ,
   output logic               out_err
`endif
);

   import burst_decoder_pkg::*;

   localparam int unsigned CNT_W = beat_cnt_w(LEN_W);

   state_e               state_q, state_d;
   logic [IN_W-1:0]      code_q, code_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [NUM_OUT-1:0]   onehot_q, onehot_d;
`ifdef BURST_DECODER_RANGE_CHK_EN
   logic                 err_q, err_d;
`endif

   logic                 last;
   logic                 beat_take;
   logic                 accept;
   logic                 in_range;
   logic [IN_W-1:0]      code_nxt;
   logic [IN_W-1:0]      dec_code;
   logic                 dec_en;
   logic [NUM_OUT-1:0]   dec_onehot;

   assign last      = (cnt_q == '0);
   assign beat_take = (state_q == RUN) && out_ready;
   assign in_ready  = (state_q == IDLE) || (last && beat_take);
   assign accept    = in_valid && in_ready;
   assign in_range  = (32'(in_code) < NUM_OUT);
   assign code_nxt  = (32'(code_q) == NUM_OUT - 1) ? '0 : code_q + 1'b1;

   // One decoder is shared: it sees the new request on accept, otherwise the next code in the burst.
   assign dec_code  = accept ? in_code : code_nxt;
   assign dec_en    = accept ? in_en   : 1'b1;

   onehot_dec #(
      .IN_W    (IN_W),
      .NUM_OUT (NUM_OUT)
   ) u_dec (
      .code_i   (dec_code),
      .en_i     (dec_en),
      .onehot_o (dec_onehot)
   );

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      cnt_d    = cnt_q;
      onehot_d = onehot_q;
`ifdef BURST_DECODER_RANGE_CHK_EN
      err_d    = err_q;
`endif
      if (accept) begin
         state_d  = RUN;
         code_d   = in_code;
         cnt_d    = (in_en && in_range) ? in_len : '0;
         onehot_d = dec_onehot;
`ifdef BURST_DECODER_RANGE_CHK_EN
         err_d    = in_en && !in_range;
`endif
      end else if (beat_take) begin
         if (last) begin
            state_d  = IDLE;
            code_d   = '0;
            cnt_d    = '0;
            onehot_d = '0;
`ifdef BURST_DECODER_RANGE_CHK_EN
            err_d    = 1'b0;
`endif
         end else begin
            code_d   = code_nxt;
            cnt_d    = cnt_q - 1'b1;
            onehot_d = dec_onehot;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         code_q   <= '0;
         cnt_q    <= '0;
         onehot_q <= '0;
`ifdef BURST_DECODER_RANGE_CHK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         cnt_q    <= cnt_d;
         onehot_q <= onehot_d;
`ifdef BURST_DECODER_RANGE_CHK_EN
         err_q    <= err_d;
`endif
      end
   end

   assign out_valid  = (state_q == RUN);
   assign out_onehot = onehot_q;
`ifdef BURST_DECODER_RANGE_CHK_EN
   assign out_err    = err_q;
`endif

endmodule
